// File: rtl/slope_operand_sequencer.sv
// Buffers one coordinate pair, saturates dx/dy and runs a single divider transaction to produce a signed 9.8 slope.
// Latency 3+D cycles (3 when dx==0); in_ready drops while the buffer is full, and the result is held until out_ready.
module slope_operand_sequencer #(
  parameter int COORD_WIDTH = 10,
  parameter int DEN_WIDTH   = 9,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_WIDTH   = 17,
  parameter int OUT_WIDTH   = 17
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [COORD_WIDTH-1:0]      x0,
  input  logic [COORD_WIDTH-1:0]      y0,
  input  logic [COORD_WIDTH-1:0]      x1,
  input  logic [COORD_WIDTH-1:0]      y1,
  output logic                        div_start,
  output logic signed [NUM_WIDTH-1:0] div_numerator,
  output logic signed [DEN_WIDTH-1:0] div_denominator,
  input  logic signed [OUT_WIDTH-1:0] div_quotient,
  input  logic                        div_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] slope,
  output logic                        vertical,
  output logic                        saturated,
  output logic                        busy
);

  localparam int DIFF_WIDTH = COORD_WIDTH + 1;
  localparam logic signed [DIFF_WIDTH-1:0] DIFF_MAX =
    {{(DIFF_WIDTH-DEN_WIDTH+1){1'b0}}, {(DEN_WIDTH-1){1'b1}}};
  localparam logic signed [DIFF_WIDTH-1:0] DIFF_MIN =
    {{(DIFF_WIDTH-DEN_WIDTH+1){1'b1}}, {(DEN_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x0;
    logic [COORD_WIDTH-1:0] y0;
    logic [COORD_WIDTH-1:0] x1;
    logic [COORD_WIDTH-1:0] y1;
  } pair_t;

  state_t                       state;
  pair_t                        pair_q;
  logic                         buf_valid;
  logic signed [DIFF_WIDTH-1:0] dx_raw;
  logic signed [DIFF_WIDTH-1:0] dy_raw;
  logic signed [DEN_WIDTH-1:0]  dx_sat;
  logic signed [DEN_WIDTH-1:0]  dy_sat;
  logic                         clip;
  logic                         dx_zero;

  function automatic logic signed [DEN_WIDTH-1:0] clamp(input logic signed [DIFF_WIDTH-1:0] v);
    if (v > DIFF_MAX)      return DIFF_MAX[DEN_WIDTH-1:0];
    else if (v < DIFF_MIN) return DIFF_MIN[DEN_WIDTH-1:0];
    else                   return v[DEN_WIDTH-1:0];
  endfunction

  // Zero-extended coordinates so the difference can span the full +/- range.
  assign dx_raw  = $signed({1'b0, pair_q.x1}) - $signed({1'b0, pair_q.x0});
  assign dy_raw  = $signed({1'b0, pair_q.y1}) - $signed({1'b0, pair_q.y0});
  assign dx_sat  = clamp(dx_raw);
  assign dy_sat  = clamp(dy_raw);
  assign clip    = (dx_raw > DIFF_MAX) || (dx_raw < DIFF_MIN) ||
                   (dy_raw > DIFF_MAX) || (dy_raw < DIFF_MIN);
  assign dx_zero = (dx_sat == '0);

  assign in_ready = !buf_valid;
  assign busy     = (state != IDLE) || buf_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pair_q          <= '0;
      buf_valid       <= 1'b0;
      div_start       <= 1'b0;
      div_numerator   <= '0;
      div_denominator <= '0;
      out_valid       <= 1'b0;
      slope           <= '0;
      vertical        <= 1'b0;
      saturated       <= 1'b0;
    end else begin
      if (in_valid && !buf_valid) begin
        pair_q    <= '{x0: x0, y0: y0, x1: x1, y1: y1};
        buf_valid <= 1'b1;
      end

      div_start <= 1'b0;

      case (state)
        IDLE: begin
          if (buf_valid) begin
            buf_valid       <= 1'b0;
            div_numerator   <= {dy_sat, {FRAC_BITS{1'b0}}};
            div_denominator <= dx_sat;
            saturated       <= clip;
            vertical        <= dx_zero;
            if (dx_zero) begin
              slope <= '0;
              state <= OUT;
            end else begin
              div_start <= 1'b1;
              state     <= START;
            end
          end
        end
        START: state <= WAIT;
        // Operands stay untouched here: the divider samples them a cycle after start.
        WAIT: begin
          if (div_done) begin
            slope     <= div_quotient;
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slope_operand_sequencer.sv
// Bench for slope_operand_sequencer: vector table, corner sequences and random traffic against a behavioural model.
module tb_slope_operand_sequencer;

  localparam int CW = 10, DW = 9, FB = 8, NW = 17, OW = 17;
  localparam int D_FIXED = 20;

  logic clk = 1'b0, reset_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0, div_done = 1'b0;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic signed [OW-1:0] div_quotient = '0;
  logic in_ready, div_start, out_valid, vertical, saturated, busy;
  logic signed [NW-1:0] div_numerator;
  logic signed [DW-1:0] div_denominator;
  logic signed [OW-1:0] slope;

  always #5 clk = ~clk;

  slope_operand_sequencer #(.COORD_WIDTH(CW), .DEN_WIDTH(DW), .FRAC_BITS(FB),
                            .NUM_WIDTH(NW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .div_start(div_start), .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_quotient(div_quotient), .div_done(div_done),
    .out_valid(out_valid), .out_ready(out_ready), .slope(slope),
    .vertical(vertical), .saturated(saturated), .busy(busy)
  );

  int n_checks = 0, n_fail = 0, cyc = 0, n_out = 0, n_starts = 0;

  function automatic void chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    int slope;
    bit vert;
    bit sat;
  } res_t;

  res_t exp_q[$];

  // Behavioural model: integer differences, clamp, truncating division.
  function automatic res_t ref_model(int ax0, int ay0, int ax1, int ay1);
    res_t r;
    int dx, dy, cdx, cdy, q, lim;
    logic signed [OW-1:0] w;
    lim = 1 << (DW - 1);
    dx  = ax1 - ax0;
    dy  = ay1 - ay0;
    cdx = (dx > lim - 1) ? lim - 1 : (dx < -lim) ? -lim : dx;
    cdy = (dy > lim - 1) ? lim - 1 : (dy < -lim) ? -lim : dy;
    r.sat  = (cdx != dx) || (cdy != dy);
    r.vert = (cdx == 0);
    q = r.vert ? 0 : (cdy * (1 << FB)) / cdx;
    w = q[OW-1:0];
    r.slope = w;
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Divider model: operands sampled one cycle after start, done D cycles after start.
  bit pend = 0, orphan = 0, prev_start = 0, rand_lat = 0;
  int age = 0, cur_d = D_FIXED, qq = 0;
  logic signed [NW-1:0] cap_num = '0;
  logic signed [DW-1:0] cap_den = '0;

  initial forever begin
    @(negedge clk);
    div_done = 1'b0;
    if (!reset_n && pend) orphan = 1;
    if (pend) begin
      age++;
      if (age == 1) begin
        cap_num = div_numerator;
        cap_den = div_denominator;
      end else if (!orphan) begin
        chk("wait_num_stable", div_numerator, cap_num);
        chk("wait_den_stable", div_denominator, cap_den);
      end
      if (age >= cur_d) begin
        qq = (cap_den == 0) ? 0 : int'(cap_num) / int'(cap_den);
        div_quotient = qq[OW-1:0];
        div_done = 1'b1;
        pend = 0;
        orphan = 0;
      end
    end
    if (div_start) begin
      chk("start_single_cycle", prev_start, 0);
      chk("start_no_overlap", pend, 0);
      n_starts++;
      pend = 1;
      age = 0;
      cur_d = rand_lat ? int'($urandom_range(1, 20)) : D_FIXED;
    end
    prev_start = div_start;
  end

  // Output monitor: hold-stability while stalled, scoreboard on handshake.
  logic signed [OW-1:0] held_slope = '0;
  bit held = 0, held_v = 0, held_s = 0;

  initial forever begin
    res_t e;
    @(negedge clk);
    #1;
    if (reset_n && out_valid) begin
      if (held) begin
        chk("hold_slope", slope, held_slope);
        chk("hold_vertical", vertical, held_v);
        chk("hold_saturated", saturated, held_s);
      end
      held = 1; held_slope = slope; held_v = vertical; held_s = saturated;
      if (out_ready) begin
        n_out++;
        held = 0;
        chk("sb_queue_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_slope", slope, e.slope);
          chk("sb_vertical", vertical, e.vert);
          chk("sb_saturated", saturated, e.sat);
        end
      end
    end else begin
      held = 0;
    end
  end

  task automatic send(input int ax0, input int ay0, input int ax1, input int ay1, output int acc_cyc);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_in_time", guard < 500, 1);
    acc_cyc = cyc;
    exp_q.push_back(ref_model(ax0, ay0, ax1, ay1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int at_cyc, output bit ok);
    int guard = 0;
    while (!out_valid && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    ok = out_valid;
    at_cyc = cyc;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    int x0, y0, x1, y1;
    int num, den, slope;
    bit vert, sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int acc, acc2, lat, st0, out0;
    bit ok;
    vecs[0] = '{0, 0, 4, 2, 512, 4, 128, 1'b0, 1'b0};
    vecs[1] = '{10, 20, 7, 26, 1536, -3, -512, 1'b0, 1'b0};
    vecs[2] = '{5, 5, 5, 9, 1024, 0, 0, 1'b1, 1'b0};
    vecs[3] = '{0, 0, 600, 100, 25600, 255, 100, 1'b0, 1'b1};
    vecs[4] = '{639, 479, 0, 0, -65536, -256, 256, 1'b0, 1'b1};
    vecs[5] = '{0, 300, 1, 0, -65536, 1, -65536, 1'b0, 1'b1};
    vecs[6] = '{100, 100, 355, 356, 65280, 255, 256, 1'b0, 1'b1};
    vecs[7] = '{356, 0, 100, 0, 0, -256, 0, 1'b0, 1'b0};

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_slope", slope, 0);
    chk("rst_vertical", vertical, 0);
    chk("rst_saturated", saturated, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_num", div_numerator, 0);
    chk("rst_den", div_denominator, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      st0 = n_starts;
      send(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, acc);
      wait_out(lat, ok);
      chk($sformatf("vec%0d_out_valid", i), ok, 1);
      chk($sformatf("vec%0d_latency", i), lat - acc, vecs[i].vert ? 3 : 3 + D_FIXED);
      chk($sformatf("vec%0d_num", i), div_numerator, vecs[i].num);
      chk($sformatf("vec%0d_den", i), div_denominator, vecs[i].den);
      chk($sformatf("vec%0d_slope", i), slope, vecs[i].slope);
      chk($sformatf("vec%0d_vertical", i), vertical, vecs[i].vert);
      chk($sformatf("vec%0d_saturated", i), saturated, vecs[i].sat);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      chk($sformatf("vec%0d_starts", i), n_starts - st0, vecs[i].vert ? 0 : 1);
      take();
    end

    // Two pairs back-to-back with the result stalled for 60 cycles.
    st0 = n_starts;
    send(0, 0, 8, 2, acc);
    send(0, 0, 3, 300, acc2);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk("b2b_in_ready_low", in_ready, 0);
    end
    chk("b2b_first_valid", out_valid, 1);
    chk("b2b_first_slope", slope, 64);
    chk("b2b_starts_while_stalled", n_starts - st0, 1);
    take();
    wait_out(lat, ok);
    chk("b2b_second_valid", ok, 1);
    chk("b2b_second_slope", slope, 21760);
    chk("b2b_second_saturated", saturated, 1);
    chk("b2b_starts_total", n_starts - st0, 2);
    take();

    // New pair accepted in the same cycle as a result handshake.
    send(2, 0, 2, 50, acc);
    wait_out(lat, ok);
    chk("simul_in_ready", in_ready, 1);
    in_valid = 1'b1;
    x0 = CW'(0); y0 = CW'(10); x1 = CW'(2); y1 = CW'(11);
    out_ready = 1'b1;
    exp_q.push_back(ref_model(0, 10, 2, 11));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_out(lat, ok);
    chk("simul_second_valid", ok, 1);
    chk("simul_second_slope", slope, 128);
    take();

    // Random traffic with random divider latency and random backpressure.
    rand_lat = 1;
    out0 = n_out;
    fork
      begin
        int racc, rx0, ry0, rx1, ry1;
        for (int k = 0; k < 40; k++) begin
          rx0 = $urandom_range(0, 1023);
          ry0 = $urandom_range(0, 1023);
          rx1 = ($urandom_range(0, 3) == 0) ? rx0 :
                ($urandom_range(0, 1) == 0) ? (rx0 + int'($urandom_range(0, 300))) % 1024 :
                int'($urandom_range(0, 1023));
          ry1 = ($urandom_range(0, 1) == 0) ? (ry0 + int'($urandom_range(0, 300))) % 1024 :
                int'($urandom_range(0, 1023));
          send(rx0, ry0, rx1, ry1, racc);
          repeat ($urandom_range(0, 5)) @(negedge clk);
        end
      end
      begin
        for (int k = 0; k < 2500; k++) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int g = 0; g < 500 && exp_q.size() != 0; g++) @(negedge clk);
    out_ready = 1'b0;
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_out_count", n_out - out0, 40);
    rand_lat = 0;
    repeat (3) @(negedge clk);

    // Reset during WAIT, then a late div_done after release.
    st0 = n_starts;
    send(0, 0, 4, 2, acc);
    repeat (8) @(negedge clk);
    chk("rstw_busy_before", busy, 1);
    chk("rstw_started", n_starts - st0, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_async_out_valid", out_valid, 0);
    chk("rstw_async_num", div_numerator, 0);
    chk("rstw_async_den", div_denominator, 0);
    chk("rstw_async_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("rstw_out_valid_low", out_valid, 0);
    end
    chk("rstw_late_done_seen", pend, 0);
    chk("rstw_slope", slope, 0);
    chk("rstw_vertical", vertical, 0);
    chk("rstw_saturated", saturated, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_in_ready", in_ready, 1);
    chk("rstw_num", div_numerator, 0);
    chk("rstw_den", div_denominator, 0);
    chk("rstw_no_restart", n_starts - st0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
